// File: rtl/leosoc_bus_pkg.sv
// Shared LeoSoC memory-bus definitions: bus widths, arbiter state encoding
// and the read data returned on an aborted transaction.
package leosoc_bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned BUS_MASK_WIDTH = BUS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, cyclically, using a
// double-width rotate followed by a lowest-bit priority encoder.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any_req,
    output logic [IW-1:0] sel
);

    localparam int unsigned SW = IW + 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [SW-1:0]  sum;

    always_comb begin
        dbl     = {req, req};
        rot     = N'(dbl >> ptr);
        any_req = |req;
        off     = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        // Offset is relative to ptr; fold back into 0..N-1.
        sum = SW'(ptr) + SW'(off);
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        sel = IW'(sum);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin, transaction-locked arbiter sharing the SoC memory bus.
// Define ARB_TIMEOUT_EN to add the GRANT watchdog and the timeout_err output.
module mem_bus_arbiter
    import leosoc_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   req_wmask,
    input  logic [NUM_REQ-1:0]                     req_wstrb,
    input  logic [NUM_REQ-1:0]                     req_rstrb,
    output logic [NUM_REQ-1:0]                     req_done,
    output logic [DATA_WIDTH-1:0]                  req_rdata,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                mem_wmask,
    output logic                                   mem_wstrb,
    output logic                                   mem_rstrb,
    input  logic                                   mem_done,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]             grant_id,
`ifdef ARB_TIMEOUT_EN
    output logic                                   timeout_err,
`endif
    output logic                                   busy
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
        $error("mem_bus_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_nxt, grant_nxt, pick_sel;
    logic              pick_any;
    logic              force_done;
    logic              hold_err;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .req     (req_wstrb | req_rstrb),
        .ptr     (rr_ptr),
        .any_req (pick_any),
        .sel     (pick_sel)
    );

`ifdef ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_flag;

    // Watchdog: counts GRANT cycles, zero everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            to_flag     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt  <= (state == GRANT) ? to_cnt + 16'd1 : '0;
            to_flag <= force_done;
            if (force_done) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign force_done = (state == GRANT) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign hold_err   = (state == HOLD) && to_flag;
`else
    assign force_done = 1'b0;
    assign hold_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    // Next state plus the bus mux; strobes and done are live only in GRANT.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        req_done  = '0;
        req_rdata = mem_rdata;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_sel;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                mem_addr  = req_addr[grant_id];
                mem_wdata = req_wdata[grant_id];
                mem_wmask = req_wmask[grant_id];
                if (!force_done) begin
                    mem_wstrb = req_wstrb[grant_id];
                    mem_rstrb = req_rstrb[grant_id];
                end
                if (mem_done || force_done) begin
                    req_done[grant_id] = 1'b1;
                    state_nxt          = HOLD;
                end
            end
            HOLD: begin
                // Address stays on the owner so the decoder's read mux stays selected.
                mem_addr  = req_addr[grant_id];
                state_nxt = IDLE;
                rr_nxt    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                if (hold_err) begin
                    req_rdata = DATA_WIDTH'(ARB_ERR_RDATA);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (NUM_REQ=2).
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mem_bus_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NR-1:0][AW-1:0]    req_addr;
    logic [NR-1:0][DW-1:0]    req_wdata;
    logic [NR-1:0][MW-1:0]    req_wmask;
    logic [NR-1:0]            req_wstrb;
    logic [NR-1:0]            req_rstrb;
    logic [NR-1:0]            req_done;
    logic [DW-1:0]            req_rdata;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wdata;
    logic [MW-1:0]            mem_wmask;
    logic                     mem_wstrb;
    logic                     mem_rstrb;
    logic                     mem_done;
    logic [DW-1:0]            mem_rdata;
    logic [0:0]               grant_id;
    logic                     busy;
`ifdef ARB_TIMEOUT_EN
    logic                     timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .req_wstrb   (req_wstrb),
        .req_rstrb   (req_rstrb),
        .req_done    (req_done),
        .req_rdata   (req_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_wstrb   (mem_wstrb),
        .mem_rstrb   (mem_rstrb),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .grant_id    (grant_id),
`ifdef ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // A requester may not raise write and read together.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(|(req_wstrb & req_rstrb)))
                else $error("illegal: simultaneous wstrb and rstrb");
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Return 1 time unit after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_wstrb = '0;
        req_rstrb = '0;
        mem_done  = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int gcnt;
        int dones;
        int bad;
        int ncyc;
        bit found;

        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        req_wstrb = '0;
        req_rstrb = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;

        // Reset state
        #1;
        check_eq("rst_busy",  64'(busy), 64'(0));
        check_eq("rst_done",  64'(req_done), 64'(0));
        check_eq("rst_grant", 64'(grant_id), 64'(0));
        check_eq("rst_mem",   64'({mem_wstrb, mem_rstrb, mem_addr, mem_wdata, mem_wmask}), 64'(0));
        do_reset();

        // Single read with a zero-latency slave
        cyc();
        req_addr[0]  = 32'h0000_0010;
        req_rstrb[0] = 1'b1;
        mem_done     = 1'b1;
        #3;
        check_eq("rd_idle_strb", 64'(mem_rstrb), 64'(0));
        check_eq("rd_idle_done", 64'(req_done), 64'(0));
        cyc(); #3;
        check_eq("rd_grant_strb", 64'(mem_rstrb), 64'(1));
        check_eq("rd_grant_wstrb", 64'(mem_wstrb), 64'(0));
        check_eq("rd_grant_addr", 64'(mem_addr), 64'h10);
        check_eq("rd_grant_done", 64'(req_done), 64'(1));
        check_eq("rd_grant_busy", 64'(busy), 64'(1));
        cyc();
        req_rstrb[0] = 1'b0;
        mem_rdata    = 32'h1234_5678;
        #3;
        check_eq("rd_hold_rdata", 64'(req_rdata), 64'h1234_5678);
        check_eq("rd_hold_strb",  64'(mem_rstrb), 64'(0));
        check_eq("rd_hold_addr",  64'(mem_addr), 64'h10);
        check_eq("rd_hold_done",  64'(req_done), 64'(0));
        check_eq("rd_hold_busy",  64'(busy), 64'(1));
        cyc(); #3;
        check_eq("rd_end_busy", 64'(busy), 64'(0));
        check_eq("rd_end_addr", 64'(mem_addr), 64'(0));
        check_eq("rd_end_done", 64'(req_done), 64'(0));

        // Contention: both write from reset, requester 0 first
        do_reset();
        cyc();
        req_addr[0]  = 32'h0000_0100;
        req_addr[1]  = 32'h0000_0200;
        req_wdata[0] = 32'hAAAA_0000;
        req_wdata[1] = 32'hBBBB_1111;
        req_wmask[0] = 4'hF;
        req_wmask[1] = 4'h3;
        req_wstrb    = 2'b11;
        mem_done     = 1'b1;
        #3;
        check_eq("ct_idle_busy", 64'(busy), 64'(0));
        cyc(); #3;
        check_eq("ct_g0_id",    64'(grant_id), 64'(0));
        check_eq("ct_g0_wdata", 64'(mem_wdata), 64'hAAAA_0000);
        check_eq("ct_g0_wmask", 64'(mem_wmask), 64'hF);
        check_eq("ct_g0_wstrb", 64'(mem_wstrb), 64'(1));
        check_eq("ct_g0_done",  64'(req_done), 64'b01);
        cyc();
        req_wstrb[0] = 1'b0;
        #3;
        check_eq("ct_h0_wstrb", 64'(mem_wstrb), 64'(0));
        cyc(); #3;
        check_eq("ct_i1_busy", 64'(busy), 64'(0));
        cyc(); #3;
        check_eq("ct_g1_id",    64'(grant_id), 64'(1));
        check_eq("ct_g1_wdata", 64'(mem_wdata), 64'hBBBB_1111);
        check_eq("ct_g1_wmask", 64'(mem_wmask), 64'h3);
        check_eq("ct_g1_addr",  64'(mem_addr), 64'h200);
        check_eq("ct_g1_done",  64'(req_done), 64'b10);
        cyc();
        req_wstrb[1] = 1'b0;
        #3;
        check_eq("ct_h1_wstrb", 64'(mem_wstrb), 64'(0));
        cyc(); #3;
        check_eq("ct_end_busy",  64'(busy), 64'(0));
        check_eq("ct_end_grant", 64'(grant_id), 64'(1));

        // Fairness: both keep requesting; rr_ptr wrapped back to 0
        cyc();
        req_wstrb = 2'b11;
        for (int t = 0; t < 10; t++) begin
            found = 1'b0;
            for (int k = 0; k < 6; k++) begin
                cyc(); #3;
                if (req_done != '0) begin
                    found = 1'b1;
                    break;
                end
            end
            check_eq("fair_wait",  64'(found), 64'(1));
            check_eq("fair_grant", 64'(grant_id), 64'(t % 2));
            check_eq("fair_done",  64'(req_done), 64'(1) << (t % 2));
            check_eq("fair_wdata", 64'(mem_wdata), (t % 2 == 0) ? 64'hAAAA_0000 : 64'hBBBB_1111);
        end

        // Slow slave: done after 7 extra cycles; requester 1 waits meanwhile
        do_reset();
        cyc();
        req_addr[0]  = 32'h0000_0100;
        req_addr[1]  = 32'h0000_0200;
        req_rstrb[0] = 1'b1;
        req_wstrb[1] = 1'b1;
        gcnt  = 0;
        dones = 0;
        bad   = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            mem_done = (gcnt == 7);
            if (dones != 0) req_rstrb[0] = 1'b0;
            #3;
            if (mem_rstrb || mem_wstrb) begin
                gcnt++;
                if (mem_addr != 32'h0000_0100 || mem_wstrb || grant_id != 1'b0) bad++;
            end
            if (req_done[0]) dones++;
            if (req_done[1]) bad++;
        end
        check_eq("slow_strobe_cycles", 64'(gcnt), 64'(8));
        check_eq("slow_done_pulses",   64'(dones), 64'(1));
        check_eq("slow_foreign",       64'(bad), 64'(0));
        check_eq("slow_hold_addr",     64'(mem_addr), 64'h100);

        // Async reset in the middle of requester 1's GRANT
        cyc();
        req_rstrb[0] = 1'b0;
        #3;
        check_eq("ar_idle_busy", 64'(busy), 64'(0));
        cyc(); #2;
        check_eq("ar_grant_wstrb", 64'(mem_wstrb), 64'(1));
        check_eq("ar_grant_id",    64'(grant_id), 64'(1));
        mem_done = 1'b1;
        reset    = 1'b1;
        #1;
        check_eq("ar_mem",   64'({mem_wstrb, mem_rstrb, mem_addr, mem_wdata, mem_wmask}), 64'(0));
        check_eq("ar_done",  64'(req_done), 64'(0));
        check_eq("ar_busy",  64'(busy), 64'(0));
        check_eq("ar_grant", 64'(grant_id), 64'(0));
        reset     = 1'b0;
        req_wstrb = '0;
        cyc(); #3;
        check_eq("ar_after_done", 64'(req_done), 64'(0));
        check_eq("ar_after_busy", 64'(busy), 64'(0));

`ifdef ARB_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=16 and a dead slave
        do_reset();
        cyc();
        req_addr[0]  = 32'h0000_0040;
        req_rstrb[0] = 1'b1;
        mem_rdata    = 32'h0000_0000;
        found = 1'b0;
        ncyc  = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(); #3;
            if (req_done[0]) begin
                found = 1'b1;
                break;
            end
            if (mem_rstrb) ncyc++;
        end
        check_eq("to_done_seen",  64'(found), 64'(1));
        check_eq("to_grant_cycs", 64'(ncyc), 64'(15));
        check_eq("to_strb_drop",  64'(mem_rstrb), 64'(0));
        cyc();
        req_rstrb[0] = 1'b0;
        #3;
        check_eq("to_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
        check_eq("to_err",   64'(timeout_err), 64'(1));
        cyc(); cyc(); cyc(); #3;
        check_eq("to_err_sticky", 64'(timeout_err), 64'(1));
        check_eq("to_end_busy",   64'(busy), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
